interval_timer_ctrl: RTL and testbench

Controller and arbiter for the shared 9-bit up-counter with enable and asynchronous clear. It lets two requesters share one counter as an interval timer. Each requester asks for an interval of T counts, and the block grants the counter to one requester at a time. It clears the counter, enables it until the count equals T, then returns a one-cycle done pulse to the granted requester. The block sits between the requesting control logic and the counter instance; the counter's `enable`, `clear` and `count` connect directly to `ctr_enable`, `ctr_clear` and `ctr_count`.

---
 rtl/interval_timer_ctrl_if.sv | 16 +
 rtl/interval_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_ctrl_if.sv
// Requester-side bundle for interval_timer_ctrl: level requests, per-requester
// targets and abort in; grant, done pulse and busy out.
interface interval_timer_ctrl_if #(
   parameter int CNT_W = 9
);
   logic [1:0]       req;
   logic [CNT_W-1:0] tgt0;
   logic [CNT_W-1:0] tgt1;
   logic             abort;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             busy;

   modport master (output req, tgt0, tgt1, abort, input gnt, done, busy);
   modport slave  (input req, tgt0, tgt1, abort, output gnt, done, busy);
endinterface

// File: rtl/interval_timer_ctrl.sv
// Two-requester arbiter/controller sharing one CNT_W-bit counter as an interval timer.
// Define TIMER_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module interval_timer_ctrl #(
   parameter int CNT_W = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   interval_timer_ctrl_if.slave  bus,
   input  logic [CNT_W-1:0]      ctr_count,
   output logic                  ctr_enable,
   output logic                  ctr_clear
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic             busy_q, busy_d;
   logic             clr_q, clr_d;
   logic [1:0]       win_s;

`ifdef TIMER_CTRL_RR_EN
   logic last_q, last_d;

   // Winner select: on contention the requester not granted most recently wins
   always_comb begin
      win_s = 2'b00;
      if (bus.req == 2'b11) begin
         if (last_q) begin
            win_s = 2'b01;
         end else begin
            win_s = 2'b10;
         end
      end else begin
         win_s = bus.req;
      end
   end

   // Pointer moves on every grant, aborted or not
   always_comb begin
      last_d = last_q;
      if ((state_q == IDLE) && (win_s != 2'b00)) begin
         last_d = win_s[1];
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Winner select: fixed priority to requester 0
   always_comb begin
      win_s = 2'b00;
      if (bus.req[0]) begin
         win_s = 2'b01;
      end else if (bus.req[1]) begin
         win_s = 2'b10;
      end else begin
         win_s = 2'b00;
      end
   end
`endif

   // Next state; counter enable is decoded here so it drops the cycle equality is reached
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      ctr_enable = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_s != 2'b00) begin
               state_d = CLR;
               tgt_d   = win_s[1] ? bus.tgt1 : bus.tgt0;
            end else begin
               state_d = IDLE;
            end
         end
         CLR: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            ctr_enable = (ctr_count != tgt_q) && !bus.abort;
            if (bus.abort) begin
               state_d = IDLE;
            end else if (ctr_count == tgt_q) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered output decodes of the next state
   always_comb begin
      if (state_q == IDLE) begin
         gnt_d = win_s;
      end else if (state_d == IDLE) begin
         gnt_d = 2'b00;
      end else begin
         gnt_d = gnt_q;
      end
      busy_d = (state_d != IDLE);
      clr_d  = (state_d == CLR);
      done_d = (state_d == DONE) ? gnt_q : 2'b00;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tgt_q   <= {CNT_W{1'b0}};
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         clr_q   <= clr_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign ctr_clear = clr_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomized and directed bench for interval_timer_ctrl against an interval-level
// reference model (cycles elapsed since grant), with a behavioural counter as the plant.
module tb_interval_timer_ctrl;
   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             reset;
   logic             ctr_enable;
   logic             ctr_clear;
   logic [CNT_W-1:0] cnt_q;
   logic             tb_clr = 1'b0;
   wire              plant_clr_s = ctr_clear | tb_clr;

   int checks_n = 0;
   int errors_n = 0;

   interval_timer_ctrl_if #(.CNT_W(CNT_W)) bus ();

   interval_timer_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .ctr_count  (cnt_q),
      .ctr_enable (ctr_enable),
      .ctr_clear  (ctr_clear)
   );

   always #5 clk = ~clk;

   // shared counter with asynchronous clear
   always @(posedge clk or posedge plant_clr_s) begin
      if (plant_clr_s) cnt_q <= '0;
      else if (ctr_enable) cnt_q <= cnt_q + 9'd1;
   end

   // reference model: an interval is "granted at edge k with target T";
   // offset 0 = clear cycle, 1..T+1 = counting, T+2 = done cycle
   bit         m_active = 1'b0;
   int         m_owner  = 0;
   int         m_tgt    = 0;
   int         m_off    = 0;
   int         m_last   = 1;
   logic [1:0] m_done   = 2'b00;
   int         m_cnt    = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_n++;
      if (obs !== exp) begin
         errors_n++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit exp_en(input logic ab);
      return m_active && (m_off >= 1) && (m_off <= m_tgt) && !ab;
   endfunction

   task automatic model_edge(input bit rs, input logic [1:0] rq, input logic ab,
                             input int t0, input int t1, input bit en_pre);
      if (en_pre) m_cnt = (m_cnt + 1) % 512;
      m_done = 2'b00;
      if (rs) begin
         m_active = 1'b0;
         m_last   = 1;
      end else if (!m_active) begin
         if (rq != 2'b00) begin
`ifdef TIMER_CTRL_RR_EN
            if (rq == 2'b11) m_owner = 1 - m_last;
            else m_owner = rq[1] ? 1 : 0;
`else
            m_owner = rq[0] ? 0 : 1;
`endif
            m_last   = m_owner;
            m_active = 1'b1;
            m_off    = 0;
            m_tgt    = (m_owner == 1) ? t1 : t0;
            m_cnt    = 0;
         end
      end else if (ab && (m_off <= m_tgt + 1)) begin
         m_active = 1'b0;
      end else if (m_off == m_tgt + 2) begin
         m_active = 1'b0;
      end else begin
         m_off++;
         if (m_off == m_tgt + 2) m_done[m_owner] = 1'b1;
      end
   endtask

   task automatic cycle();
      logic [1:0] rq;
      logic       ab;
      bit         rs;
      int         t0, t1;
      bit         en;
      logic [1:0] eg;
      @(negedge clk);
      check_val("ctr_enable", {31'd0, ctr_enable}, {31'd0, exp_en(bus.abort)});
      rq = bus.req;
      ab = bus.abort;
      rs = reset;
      t0 = int'(bus.tgt0);
      t1 = int'(bus.tgt1);
      en = exp_en(ab);
      @(posedge clk);
      model_edge(rs, rq, ab, t0, t1, en);
      #1;
      eg = 2'b00;
      if (m_active) eg[m_owner] = 1'b1;
      check_val("gnt", {30'd0, bus.gnt}, {30'd0, eg});
      check_val("done", {30'd0, bus.done}, {30'd0, m_done});
      check_val("busy", {31'd0, bus.busy}, {31'd0, m_active});
      check_val("ctr_clear", {31'd0, ctr_clear}, {31'd0, (m_active && m_off == 0)});
      check_val("ctr_count", {23'd0, cnt_q}, m_cnt);
   endtask

   // run n cycles; unless held, a request drops once its done has pulsed
   task automatic run(input int n, input bit hold);
      for (int i = 0; i < n; i++) begin
         cycle();
         if (!hold) bus.req = bus.req & ~m_done;
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.req   = 2'b00;
      bus.tgt0  = '0;
      bus.tgt1  = '0;
      bus.abort = 1'b0;
      @(posedge clk);
      #1;
      tb_clr = 1'b1;
      #1;
      tb_clr = 1'b0;
      run(2, 1'b0);
      reset = 1'b0;
      run(1, 1'b0);

      bus.req = 2'b01; bus.tgt0 = 9'd5;
      run(10, 1'b0);

      bus.req = 2'b10; bus.tgt1 = 9'd0;
      run(5, 1'b0);

      bus.req = 2'b11; bus.tgt0 = 9'd3; bus.tgt1 = 9'd4;
      run(20, 1'b1);
      bus.req = 2'b00;
      run(10, 1'b0);

      bus.req = 2'b01; bus.tgt0 = 9'd100;
      run(4, 1'b1);
      bus.req = 2'b00; bus.abort = 1'b1;
      run(1, 1'b0);
      bus.abort = 1'b0;
      run(4, 1'b0);

      bus.req = 2'b01; bus.tgt0 = 9'd100;
      run(39, 1'b1);
      bus.req = 2'b00; reset = 1'b1;
      run(1, 1'b0);
      reset = 1'b0;
      run(2, 1'b0);
      bus.req = 2'b01; bus.tgt0 = 9'd3;
      run(8, 1'b0);

      bus.req = 2'b01; bus.tgt0 = 9'd511;
      run(518, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         logic [1:0] r;
         r = bus.req;
         for (int b = 0; b < 2; b++) begin
            if (r[b] && m_done[b] && ($urandom_range(0, 1) == 0)) r[b] = 1'b0;
            else if (!r[b] && ($urandom_range(0, 3) == 0)) r[b] = 1'b1;
         end
         bus.req   = r;
         bus.tgt0  = 9'($urandom_range(0, 12));
         bus.tgt1  = 9'($urandom_range(0, 12));
         bus.abort = ($urandom_range(0, 24) == 0);
         reset     = ($urandom_range(0, 299) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
      $finish;
   end
endmodule
